// File: rtl/leaky_relu_fwd_mask_buffer.sv
// Forward leaky ReLU lane with an in-order pre-activation FIFO for the backward pass.
// Define LR_FWD_SAT_EN to saturate the scaled negative path instead of wrapping it.
module leaky_relu_fwd_mask_buffer #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int DEPTH  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lr_valid_in,
  input  logic [DATA_W-1:0]          lr_data_in,
  input  logic [DATA_W-1:0]          lr_leak_factor_in,
  output logic                       lr_ready_out,
  output logic                       lr_valid_out,
  output logic [DATA_W-1:0]          lr_data_out,
  input  logic                       flush_in,
  input  logic                       mask_pop_in,
  output logic                       mask_valid_out,
  output logic [DATA_W-1:0]          mask_pre_out,
  output logic [$clog2(DEPTH):0]     mask_count_out,
  output logic                       overflow_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0]          mem [DEPTH];
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [CW-1:0]              count;
  logic                       accept;
  logic                       pop;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [2*DATA_W-1:0] shifted;
  logic [DATA_W-1:0]          scaled;
  logic [DATA_W-1:0]          act;

`ifdef LR_FWD_SAT_EN
  localparam logic signed [2*DATA_W-1:0] SAT_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [2*DATA_W-1:0] SAT_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

  assign lr_ready_out   = !rst && !flush_in && (count < CW'(DEPTH));
  assign accept         = lr_valid_in && lr_ready_out;
  assign pop            = mask_pop_in && (count != '0) && !flush_in;
  assign mask_valid_out = (count != '0);
  assign mask_pre_out   = (count != '0) ? mem[rd_ptr] : '0;
  assign mask_count_out = count;

  // Negative inputs take the leak path; the shift floors toward -inf.
  always_comb begin
    prod    = $signed(lr_data_in) * $signed(lr_leak_factor_in);
    shifted = prod >>> FRAC_W;
`ifdef LR_FWD_SAT_EN
    if (shifted > SAT_MAX)
      scaled = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN)
      scaled = SAT_MIN[DATA_W-1:0];
    else
      scaled = shifted[DATA_W-1:0];
`else
    scaled = shifted[DATA_W-1:0];
`endif
    act = lr_data_in[DATA_W-1] ? scaled : lr_data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lr_valid_out <= 1'b0;
      lr_data_out  <= '0;
    end else begin
      lr_valid_out <= accept;
      lr_data_out  <= accept ? act : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem[wr_ptr] <= lr_data_in;
  end

  // Flush wins over push/pop and also clears the sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_out <= 1'b0;
    end else if (flush_in) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_out <= 1'b0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (lr_valid_in && !lr_ready_out)
        overflow_out <= 1'b1;
    end
  end

endmodule
